// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 frame receiver with parity/stop/watchdog checks, E0/F0 prefix folding and a FWFT code FIFO.
module ps2_rx_fifo #(
    parameter int SYNC_STAGES    = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter bit DECODE_PREFIX  = 1'b1
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_ps2_clk,
    input  logic                          i_ps2_data,
    output logic [7:0]                    o_rd_data,
    output logic                          o_rd_ext,
    output logic                          o_rd_release,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_parity_err,
    output logic                          o_frame_err,
    output logic                          o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [7:0]             r_shift;
    logic [2:0]             r_bitcnt;
    logic                   r_par;
    logic [WW-1:0]          r_wd;
    logic                   r_ext_pend;
    logic                   r_rel_pend;
    logic [9:0]             r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;

    logic          w_fall;
    logic          w_bit;
    logic [WW-1:0] w_wd_inc;
    logic          w_timeout;
    logic          w_stop_edge;
    logic          w_par_ok;
    logic          w_good;
    logic          w_is_e0;
    logic          w_is_f0;
    logic          w_push;
    logic          w_clr_pend;
    logic          w_pop;
    logic          w_full;
    logic          w_wr;
    logic [9:0]    w_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data};
        end
    end

    // Oldest stage still high while the one behind it has gone low.
    assign w_fall = r_clk_sync[SYNC_STAGES-1] & ~r_clk_sync[SYNC_STAGES-2];
    assign w_bit  = r_data_sync[SYNC_STAGES-1];

    // Timeout fires in the cycle the counter would reach TIMEOUT_CYCLES-1.
    assign w_wd_inc  = r_wd + 1'b1;
    assign w_timeout = (r_state != S_IDLE) && !w_fall && (w_wd_inc == WW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout)
            w_next = S_IDLE;
        else if (w_fall) begin
            case (r_state)
                S_IDLE:   w_next = w_bit ? S_IDLE : S_DATA;
                S_DATA:   w_next = (r_bitcnt == 3'd7) ? S_PARITY : S_DATA;
                S_PARITY: w_next = S_STOP;
                S_STOP:   w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_stop_edge  = w_fall && (r_state == S_STOP);
        w_par_ok     = ^{r_shift, r_par};
        w_good       = w_stop_edge && w_par_ok && w_bit;
        w_is_e0      = DECODE_PREFIX && (r_shift == 8'hE0);
        w_is_f0      = DECODE_PREFIX && (r_shift == 8'hF0);
        w_push       = w_good && !w_is_e0 && !w_is_f0;
        o_parity_err = w_stop_edge && !w_par_ok;
        o_frame_err  = (w_stop_edge && w_par_ok && !w_bit) || w_timeout;
        w_clr_pend   = o_parity_err || o_frame_err || w_push;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_par    <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_wd <= (r_state == S_IDLE || w_fall || w_timeout) ? '0 : w_wd_inc;
            if (w_fall && r_state == S_IDLE)
                r_bitcnt <= '0;
            if (w_fall && r_state == S_DATA) begin
                r_shift  <= {w_bit, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_fall && r_state == S_PARITY)
                r_par <= w_bit;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (w_clr_pend) begin
            r_ext_pend <= 1'b0;
            r_rel_pend <= 1'b0;
        end else if (w_good) begin
            r_ext_pend <= r_ext_pend | w_is_e0;
            r_rel_pend <= r_rel_pend | w_is_f0;
        end
    end

    assign w_pop      = o_rd_valid && i_rd_ready;
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_wr       = w_push && (!w_full || w_pop);
    assign o_overflow = w_push && w_full && !w_pop;

    always_ff @(posedge i_clk) begin
        if (w_wr)
            r_mem[r_wr_ptr] <= {r_ext_pend, r_rel_pend, r_shift};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
            r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
            r_count  <= (w_wr && !w_pop) ? r_count + 1'b1 :
                        (w_pop && !w_wr) ? r_count - 1'b1 : r_count;
        end
    end

    always_comb begin
        w_head       = r_mem[r_rd_ptr];
        o_rd_valid   = (r_count != '0);
        o_rd_data    = o_rd_valid ? w_head[7:0] : 8'h00;
        o_rd_ext     = o_rd_valid && w_head[9];
        o_rd_release = o_rd_valid && w_head[8];
        o_fifo_count = r_count;
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: table-driven, directed and randomized checks of ps2_rx_fifo against a frame-level model.
module tb_ps2_rx_fifo;
    localparam int S  = 3;
    localparam int D  = 4;
    localparam int T  = 50;
    localparam int H  = 8;
    localparam int CW = $clog2(D) + 1;
    localparam int NV = 23;

    typedef struct {
        logic [7:0] b;
        bit         flip;
        bit         stop;
        int         npush;
        logic [9:0] ent;
        int         npar;
        int         nfrm;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          ps2_clk = 1'b1;
    logic          ps2_data = 1'b1;
    logic          rd_ready = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_ext, rd_release, rd_valid;
    logic [CW-1:0] fifo_count;
    logic          parity_err, frame_err, overflow;

    int         cyc = 0;
    int         n_par = 0, n_frm = 0, n_ovf = 0, n_vcyc = 0, last_frm_cyc = 0;
    logic [9:0] got[$];
    int         got_cyc[$];
    int         n_chk = 0, n_pass = 0;
    int         fall_cyc = 0;
    bit         rand_rdy = 1'b0;
    vec_t       tbl[NV];
    logic [9:0] exq[$];
    bit         m_ext = 1'b0, m_rel = 1'b0;
    int         e_par = 0, e_frm = 0;

    ps2_rx_fifo #(.SYNC_STAGES(S), .FIFO_DEPTH(D), .TIMEOUT_CYCLES(T), .DECODE_PREFIX(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
        .o_rd_data(rd_data), .o_rd_ext(rd_ext), .o_rd_release(rd_release), .o_rd_valid(rd_valid),
        .i_rd_ready(rd_ready), .o_fifo_count(fifo_count),
        .o_parity_err(parity_err), .o_frame_err(frame_err), .o_overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (parity_err) n_par <= n_par + 1;
            if (frame_err) begin
                n_frm <= n_frm + 1;
                last_frm_cyc <= cyc;
            end
            if (overflow) n_ovf <= n_ovf + 1;
            if (rd_valid) n_vcyc <= n_vcyc + 1;
            if (rd_valid && rd_ready) begin
                got.push_back({rd_ext, rd_release, rd_data});
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string nm, input int g, input int e);
        n_chk++;
        if (g == e) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, g, e);
    endtask

    function automatic int got_at(input int i);
        if (got.size() > i) return int'(got[i]);
        return -1;
    endfunction

    function automatic int got_cyc_at(input int i);
        if (got_cyc.size() > i) return got_cyc[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) rd_ready = ($urandom_range(0, 3) != 0);
    endtask

    // nfall falling edges of an 11-bit frame; optional one-cycle rd_ready in the stop-detect cycle.
    task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop, input int nfall, input bit pop_at_stop);
        logic [10:0] f;
        f = {stop, (~^b) ^ flip, b, 1'b0};
        for (int k = 0; k < nfall; k++) begin
            ps2_data = f[k];
            repeat (H) tick();
            ps2_clk = 1'b0;
            fall_cyc = cyc;
            for (int i = 0; i < H; i++) begin
                if (pop_at_stop && k == 10) rd_ready = (i == S - 1);
                tick();
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) tick();
    endtask

    task automatic model(input logic [7:0] b, input bit flip, input bit stop);
        if (flip) begin
            e_par++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (!stop) begin
            e_frm++;
            m_ext = 1'b0;
            m_rel = 1'b0;
        end else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
            exq.push_back({m_ext, m_rel, b});
            m_ext = 1'b0;
            m_rel = 1'b0;
        end
    endtask

    initial begin
        int p0, f0, o0, v0, g0, fc;
        logic [7:0] b;
        bit fl, st;
        tbl[0]  = '{8'h1C, 1'b0, 1'b1, 1, 10'h01C, 0, 0};
        tbl[1]  = '{8'hE0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[2]  = '{8'hF0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[3]  = '{8'h74, 1'b0, 1'b1, 1, 10'h374, 0, 0};
        tbl[4]  = '{8'h74, 1'b0, 1'b1, 1, 10'h074, 0, 0};
        tbl[5]  = '{8'h1C, 1'b1, 1'b1, 0, 10'h000, 1, 0};
        tbl[6]  = '{8'h32, 1'b0, 1'b1, 1, 10'h032, 0, 0};
        tbl[7]  = '{8'h1C, 1'b0, 1'b0, 0, 10'h000, 0, 1};
        tbl[8]  = '{8'h32, 1'b0, 1'b1, 1, 10'h032, 0, 0};
        tbl[9]  = '{8'hE0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[10] = '{8'h1C, 1'b1, 1'b0, 0, 10'h000, 1, 0};
        tbl[11] = '{8'h15, 1'b0, 1'b1, 1, 10'h015, 0, 0};
        tbl[12] = '{8'hF0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[13] = '{8'hF0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[14] = '{8'hE0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[15] = '{8'h11, 1'b0, 1'b1, 1, 10'h311, 0, 0};
        tbl[16] = '{8'hE0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[17] = '{8'h5A, 1'b0, 1'b0, 0, 10'h000, 0, 1};
        tbl[18] = '{8'h5A, 1'b0, 1'b1, 1, 10'h05A, 0, 0};
        tbl[19] = '{8'hF0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[20] = '{8'h23, 1'b0, 1'b1, 1, 10'h123, 0, 0};
        tbl[21] = '{8'hE0, 1'b0, 1'b1, 0, 10'h000, 0, 0};
        tbl[22] = '{8'h23, 1'b0, 1'b1, 1, 10'h223, 0, 0};

        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("reset outputs", int'({rd_valid, rd_ext, rd_release, parity_err, frame_err, overflow, rd_data, fifo_count}), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        rd_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            p0 = n_par; f0 = n_frm; v0 = n_vcyc; g0 = got.size();
            send_frame(tbl[i].b, tbl[i].flip, tbl[i].stop, 11, 1'b0);
            repeat (4) tick();
            check($sformatf("vec%0d pushes", i), got.size() - g0, tbl[i].npush);
            check($sformatf("vec%0d valid cycles", i), n_vcyc - v0, tbl[i].npush);
            if (tbl[i].npush == 1) check($sformatf("vec%0d entry", i), got_at(g0), int'(tbl[i].ent));
            check($sformatf("vec%0d parity_err", i), n_par - p0, tbl[i].npar);
            check($sformatf("vec%0d frame_err", i), n_frm - f0, tbl[i].nfrm);
            check($sformatf("vec%0d count", i), int'(fifo_count), 0);
            // S-1 cycles to detect the stop edge, then one cycle to appear at the head.
            if (i == 0) check("push latency", got_cyc_at(g0) - fall_cyc, S);
        end

        // Watchdog: E0 then a frame abandoned after 4 data bits; pending E0 must be dropped.
        f0 = n_frm; p0 = n_par; g0 = got.size();
        send_frame(8'hE0, 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0);
        fc = fall_cyc;
        repeat (80) tick();
        check("timeout frame_err", n_frm - f0, 1);
        check("timeout delay", last_frm_cyc - fc, (S - 1) + (T - 1));
        check("timeout no parity_err", n_par - p0, 0);
        check("timeout no push", got.size() - g0, 0);
        send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0);
        repeat (4) tick();
        check("after timeout entry", got_at(g0), 10'h02A);
        check("after timeout frame_err", n_frm - f0, 1);

        // Overflow: five codes into a four-deep FIFO with no reader.
        rd_ready = 1'b0;
        o0 = n_ovf; g0 = got.size();
        for (int k = 0; k < 4; k++) begin
            send_frame(8'h10 + 8'(k), 1'b0, 1'b1, 11, 1'b0);
            check($sformatf("fill count %0d", k), int'(fifo_count), k + 1);
        end
        check("no overflow before full", n_ovf - o0, 0);
        send_frame(8'h14, 1'b0, 1'b1, 11, 1'b0);
        check("overflow pulse", n_ovf - o0, 1);
        check("full count", int'(fifo_count), D);
        check("head held", int'({rd_valid, rd_data}), 9'h110);
        rd_ready = 1'b1;
        repeat (10) tick();
        check("drain size", got.size() - g0, 4);
        for (int k = 0; k < 4; k++) check($sformatf("drain %0d", k), got_at(g0 + k), 16 + k);
        check("drained count", int'(fifo_count), 0);

        // Full FIFO with a pop in the same cycle as a push.
        rd_ready = 1'b0;
        o0 = n_ovf; g0 = got.size();
        for (int k = 0; k < 4; k++) send_frame(8'h10 + 8'(k), 1'b0, 1'b1, 11, 1'b0);
        send_frame(8'h20, 1'b0, 1'b1, 11, 1'b1);
        check("push+pop no overflow", n_ovf - o0, 0);
        check("push+pop count", int'(fifo_count), D);
        rd_ready = 1'b1;
        repeat (10) tick();
        check("push+pop drain size", got.size() - g0, 5);
        for (int k = 0; k < 4; k++) check($sformatf("push+pop drain %0d", k), got_at(g0 + k), 16 + k);
        check("push+pop last", got_at(g0 + 4), 10'h020);

        // Reset in the middle of a frame with an entry waiting.
        rd_ready = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
        check("pre-reset head", int'({rd_valid, rd_data}), 9'h155);
        send_frame(8'h66, 1'b0, 1'b1, 4, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid-frame reset outputs", int'({rd_valid, rd_ext, rd_release, parity_err, frame_err, overflow, rd_data, fifo_count}), 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        rd_ready = 1'b1;
        p0 = n_par; f0 = n_frm; g0 = got.size();
        send_frame(8'h3B, 1'b0, 1'b1, 11, 1'b0);
        repeat (4) tick();
        check("post-reset pushes", got.size() - g0, 1);
        check("post-reset entry", got_at(g0), 10'h03B);
        check("post-reset errors", (n_par - p0) + (n_frm - f0), 0);

        // Randomized frames, random reader, frame-level model.
        p0 = n_par; f0 = n_frm; o0 = n_ovf; g0 = got.size();
        e_par = 0; e_frm = 0;
        rand_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: b = 8'hE0;
                1: b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            case ($urandom_range(0, 9))
                0: begin fl = 1'b1; st = 1'b1; end
                1: begin fl = 1'b0; st = 1'b0; end
                2: begin fl = 1'b1; st = 1'b0; end
                default: begin fl = 1'b0; st = 1'b1; end
            endcase
            model(b, fl, st);
            send_frame(b, fl, st, 11, 1'b0);
        end
        rand_rdy = 1'b0;
        rd_ready = 1'b1;
        repeat (20) tick();
        check("random push count", got.size() - g0, exq.size());
        foreach (exq[k]) check($sformatf("random entry %0d", k), got_at(g0 + k), int'(exq[k]));
        check("random parity_err", n_par - p0, e_par);
        check("random frame_err", n_frm - f0, e_frm);
        check("random overflow", n_ovf - o0, 0);
        check("random final count", int'(fifo_count), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Next-generation PS/2 keyboard receiver. Deserialises 11-bit PS/2 frames and checks odd parity and the stop bit.
- Guards each frame with a watchdog timeout.
- Optionally folds E0/F0 prefix bytes into per-code flags.
- Queues decoded codes in a parametrised first-word-fall-through FIFO with a valid/ready read handshake. Downstream keyboard-decode logic drains it at its own pace.

Parameters:
- SYNC_STAGES, 3, synchroniser depth for ps2_clk/ps2_data; minimum 2.
- FIFO_DEPTH, 8, entry count; power of 2, minimum 2.
- TIMEOUT_CYCLES, 100000, max clk cycles between falling ps2_clk edges inside a frame; minimum 2.
- DECODE_PREFIX, 1, 1 = consume E0/F0 and set flags; 0 = pass all bytes raw with flags 0.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- ps2_clk  in  1  PS/2 clock line, asynchronous
- ps2_data  in  1  PS/2 data line, asynchronous
- rd_data  out  8  head-of-FIFO scancode; 0 when rd_valid=0
- rd_ext  out  1  head entry was preceded by E0; 0 when rd_valid=0
- rd_release  out  1  head entry was preceded by F0; 0 when rd_valid=0
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts head entry
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries
- parity_err  out  1  one-cycle pulse, parity check failed
- frame_err  out  1  one-cycle pulse, stop bit 0 or watchdog timeout
- overflow  out  1  one-cycle pulse, good code dropped because FIFO full

Behaviour:
- Reset (rst_n=0, async):
  - Synchroniser stages all 1; FSM to IDLE; pointers, count and pending flags to 0; watchdog to 0.
  - All outputs 0. FIFO contents discarded.
  - A reset mid-frame abandons the frame; nothing is pushed.
- Synchroniser and sampling:
  - Falling edge = last two synchroniser stages equal 1 then 0.
  - Data is sampled from the last data stage in the same cycle.
- FSM, advancing only on falling edges:
  - IDLE: sampled 0 -> DATA, bit count cleared. Sampled 1 -> stay IDLE (spurious edge, no error).
  - DATA: shift LSB first (new bit into bit 7, shift right). After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: evaluate the frame, then -> IDLE.
- Frame evaluation on the stop-bit edge:
  - The frame is good when the XOR of the 8 data bits and the parity bit is 1, and stop = 1.
  - Parity wrong: parity_err pulses; the frame is discarded.
  - Stop = 0 (parity correct): frame_err pulses; the frame is discarded.
  - Both wrong: only parity_err pulses.
  - Any error clears both pending flags.
- Watchdog:
  - Counter clears on every falling edge and in IDLE; it increments in all other states.
  - On reaching TIMEOUT_CYCLES-1: frame_err pulses for one cycle, FSM -> IDLE, partial frame discarded, pending flags cleared.
- Prefix decode (DECODE_PREFIX=1):
  - Good byte E0: sets ext_pend, no push.
  - Good byte F0: sets rel_pend, no push.
  - Any other good byte: pushes {ext_pend, rel_pend, byte}, then clears both flags.
  - Repeated E0/F0 bytes keep their flags set.
- Raw mode (DECODE_PREFIX=0): every good byte is pushed with flags 0.
- Push timing and latency:
  - The push writes on the clk edge at the end of the cycle in which the stop-bit falling edge is detected.
  - rd_valid and the entry appear the next cycle: 1 cycle latency from detection.
- FIFO:
  - Pop occurs when rd_valid && rd_ready. Pointers wrap modulo FIFO_DEPTH.
  - fifo_count is +1 on push only, -1 on pop only, unchanged on push+pop.
  - Push while full without a same-cycle pop: the entry is dropped, overflow pulses, and contents and count are unchanged.
  - Push while full with a same-cycle pop: both occur, no overflow.
  - Pop while empty is ignored; rd_ready has no effect when rd_valid=0.
  - rd_data, rd_ext and rd_release are stable while rd_valid=1 and rd_ready=0.

Test Plan:
- Send frame 0x1C with correct parity and stop, rd_ready=1 -> exactly one cycle with rd_valid=1, rd_data=0x1C, flags 0, no error pulses, fifo_count returns to 0.
- Send E0, F0, 0x74 with DECODE_PREFIX=1 -> exactly one entry: rd_data=0x74, rd_ext=1, rd_release=1. A following 0x74 -> flags 0x0.
- Send 0x1C with a flipped parity bit -> parity_err one pulse, no push. Next good 0x32 -> pushed with flags 0. Repeat with stop=0 -> frame_err only.
- TIMEOUT_CYCLES=50: stop ps2_clk after 4 data bits -> frame_err pulses exactly 49 cycles after the last falling edge. The next full frame 0x2A is received correctly.
- FIFO_DEPTH=4, rd_ready=0, send 5 codes 0x10..0x14 -> fifo_count=4, overflow pulses once on 0x14. Drain yields 0x10..0x13 in order.
- FIFO full, assert rd_ready in the cycle a new code (0x20) pushes -> no overflow, count stays 4, 0x20 is read last. Separately, assert rst_n=0 mid-frame -> all outputs 0 immediately, and the next frame is received cleanly.
